// File: rtl/cmd_sched_pkg.sv
// Shared types for the command execution scheduler: FSM states,
// impulse type codes and the latched command record.
package cmd_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_START,
        PERIOD,
        DONE
    } state_t;

    localparam logic [1:0] TYPE_FIXED = 2'd0;
    localparam logic [1:0] TYPE_CHIRP = 2'd1;
    localparam logic [1:0] TYPE_HOP   = 2'd2;
    localparam logic [1:0] TYPE_RSVD  = 2'd3;

    typedef struct packed {
        logic [63:0] time_start;
        logic [47:0] freq;
        logic [47:0] freq_step;
        logic [31:0] freq_rate;
        logic [15:0] n;
        logic [1:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } cmd_t;

endpackage

// File: rtl/cmd_exec_sched_imp_timer.sv
// Per-impulse offset counter and IMP/BLANK/NCO_LOAD window decode.
// Gates are registered from the next offset so they line up with it.
module imp_timer
    import cmd_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic [31:0] tp,
    input  logic [31:0] ti,
    input  logic [31:0] tb1,
    input  logic [31:0] tb2,
    output logic        imp,
    output logic        blank,
    output logic        nco_load,
    output logic        period_end
);

    logic        active_q, active_d;
    logic [32:0] off_q, off_d;
    logic        imp_q, imp_d;
    logic        blank_q, blank_d;
    logic        load_q, load_d;
    logic [32:0] win, tp_eff, imp_end, ld_off;

    always_comb begin
        win     = {1'b0, tb1} + {1'b0, ti} + {1'b0, tb2};
        imp_end = {1'b0, tb1} + {1'b0, ti};
        tp_eff  = (tp == 32'd0) ? win : {1'b0, tp};
        if (tp_eff == 33'd0) tp_eff = 33'd1;
        ld_off  = (tb1 == 32'd0) ? 33'd0 : {1'b0, tb1} - 33'd1;

        period_end = active_q && (off_q == tp_eff - 33'd1);

        active_d = active_q;
        off_d    = off_q;
        if (halt) begin
            active_d = 1'b0;
        end else if (start) begin
            active_d = 1'b1;
            off_d    = 33'd0;
        end else if (period_end) begin
            off_d = 33'd0;
        end else if (active_q) begin
            off_d = off_q + 33'd1;
        end

        // off_d never reaches tp_eff, so the Tp clip is implicit
        imp_d   = active_d && (off_d >= {1'b0, tb1}) && (off_d < imp_end);
        blank_d = active_d && (off_d < win);
        load_d  = active_d && (off_d == ld_off);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            off_q    <= '0;
            imp_q    <= 1'b0;
            blank_q  <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            off_q    <= off_d;
            imp_q    <= imp_d;
            blank_q  <= blank_d;
            load_q   <= load_d;
        end
    end

    assign imp      = imp_q;
    assign blank    = blank_q;
    assign nco_load = load_q;

endmodule

// File: rtl/cmd_exec_sched.sv
// Single-command impulse-train scheduler with one pending slot.
// Optional ABORT input when CMD_SCHED_ABORT_EN is defined.
module cmd_exec_sched
    import cmd_sched_pkg::*;
#(
    parameter int unsigned REQ_LEN    = 4,
    parameter int unsigned ARM_MARGIN = 2
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [63:0] TIME,
    input  logic        DATA_WR,
    input  logic [47:0] FREQ,
    input  logic [47:0] FREQ_STEP,
    input  logic [31:0] FREQ_RATE,
    input  logic [63:0] TIME_START,
    input  logic [15:0] N_impulse,
    input  logic [1:0]  TYPE_impulse,
    input  logic [31:0] Interval_Ti,
    input  logic [31:0] Interval_Tp,
    input  logic [31:0] Tblank1,
    input  logic [31:0] Tblank2,
`ifdef CMD_SCHED_ABORT_EN
    input  logic        ABORT,
`endif
    output logic        REQ_COMM,
    output logic        IMP,
    output logic        BLANK,
    output logic        NCO_LOAD,
    output logic [47:0] NCO_FREQ,
    output logic [47:0] NCO_STEP,
    output logic [31:0] NCO_RATE,
    output logic        CHIRP_EN,
    output logic        BUSY,
    output logic [15:0] IMP_CNT,
    output logic        ERR_LATE
);

    state_t      state_q, state_d;
    cmd_t        act_q, act_d, pend_q, pend_d, incoming;
    logic        pend_v_q, pend_v_d;
    logic        dwr_q, boot_q;
    logic        req_q, req_d;
    logic [7:0]  req_cnt_q, req_cnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d, busy_q, busy_d, chirp_q, chirp_d;
    logic [47:0] nfreq_q, nfreq_d, nstep_q, nstep_d;
    logic [31:0] nrate_q, nrate_d;
    logic        wr_rise, abort, start, halt, req_fire, period_end;

    always_comb begin
        incoming.time_start = TIME_START;
        incoming.freq       = FREQ;
        incoming.freq_step  = FREQ_STEP;
        incoming.freq_rate  = FREQ_RATE;
        incoming.n          = N_impulse;
        incoming.typ        = TYPE_impulse;
        incoming.ti         = Interval_Ti;
        incoming.tp         = Interval_Tp;
        incoming.tb1        = Tblank1;
        incoming.tb2        = Tblank2;
    end

    always_comb begin
        wr_rise = DATA_WR && !dwr_q;
`ifdef CMD_SCHED_ABORT_EN
        abort = ABORT && (state_q != IDLE);
`else
        abort = 1'b0;
`endif
        state_d  = state_q;
        act_d    = act_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        nfreq_d  = nfreq_q;
        nstep_d  = nstep_q;
        nrate_d  = nrate_q;
        start    = 1'b0;
        halt     = 1'b0;
        req_fire = boot_q;

        unique case (state_q)
            IDLE: begin
                if (wr_rise) begin
                    act_d   = incoming;
                    state_d = ARM;
                end else if (pend_v_q) begin
                    act_d    = pend_q;
                    pend_v_d = 1'b0;
                    state_d  = ARM;
                end
            end
            ARM: begin
                cnt_d = '0;
                if (act_q.n == 16'd0) begin
                    state_d = DONE;
                end else if (TIME + 64'(ARM_MARGIN) >= act_q.time_start) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                if (TIME > act_q.time_start) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (TIME == act_q.time_start - 64'd1) begin
                    start   = 1'b1;
                    state_d = PERIOD;
                    nfreq_d = act_q.freq;
                    nstep_d = act_q.freq_step;
                    nrate_d = act_q.freq_rate;
                end
            end
            PERIOD: begin
                if (period_end) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == act_q.n) begin
                        halt    = 1'b1;
                        state_d = DONE;
                    end else if (act_q.typ == TYPE_HOP) begin
                        nfreq_d = nfreq_q + act_q.freq_step;
                    end
                end
            end
            DONE: begin
                if (pend_v_q && !abort) begin
                    act_d    = pend_q;
                    pend_v_d = 1'b0;
                    state_d  = ARM;
                end else begin
                    req_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture after consumption so a same-cycle write survives DONE
        if (wr_rise && state_q != IDLE) begin
            pend_d   = incoming;
            pend_v_d = 1'b1;
        end

        if (abort) begin
            pend_v_d = 1'b0;
            halt     = 1'b1;
            if (state_q != DONE) state_d = DONE;
        end

        req_d     = req_q;
        req_cnt_d = req_cnt_q;
        if (req_fire) begin
            req_d     = 1'b1;
            req_cnt_d = 8'(REQ_LEN - 1);
        end else if (req_cnt_q != 8'd0) begin
            req_cnt_d = req_cnt_q - 8'd1;
        end else begin
            req_d = 1'b0;
        end

        busy_d  = (state_d != IDLE);
        chirp_d = (act_d.typ == TYPE_CHIRP);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            act_q     <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            dwr_q     <= 1'b0;
            boot_q    <= 1'b1;
            req_q     <= 1'b0;
            req_cnt_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            chirp_q   <= 1'b0;
            nfreq_q   <= '0;
            nstep_q   <= '0;
            nrate_q   <= '0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            dwr_q     <= DATA_WR;
            boot_q    <= 1'b0;
            req_q     <= req_d;
            req_cnt_q <= req_cnt_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            chirp_q   <= chirp_d;
            nfreq_q   <= nfreq_d;
            nstep_q   <= nstep_d;
            nrate_q   <= nrate_d;
        end
    end

    imp_timer u_timer (
        .clk        (CLK),
        .rst        (rst),
        .start      (start),
        .halt       (halt),
        .tp         (act_q.tp),
        .ti         (act_q.ti),
        .tb1        (act_q.tb1),
        .tb2        (act_q.tb2),
        .imp        (IMP),
        .blank      (BLANK),
        .nco_load   (NCO_LOAD),
        .period_end (period_end)
    );

    assign REQ_COMM = req_q;
    assign NCO_FREQ = nfreq_q;
    assign NCO_STEP = nstep_q;
    assign NCO_RATE = nrate_q;
    assign CHIRP_EN = chirp_q;
    assign BUSY     = busy_q;
    assign IMP_CNT  = cnt_q;
    assign ERR_LATE = err_q;

endmodule

// File: tb/tb_cmd_exec_sched.sv
// Scoreboard bench for cmd_exec_sched: expected pulses and loads are
// queued when commands are sent and matched as the DUT produces them.
module tb_cmd_exec_sched;

    logic        CLK = 1'b0;
    logic        rst;
    logic [63:0] TIME;
    logic        DATA_WR;
    logic [47:0] FREQ, FREQ_STEP;
    logic [31:0] FREQ_RATE;
    logic [63:0] TIME_START;
    logic [15:0] N_impulse;
    logic [1:0]  TYPE_impulse;
    logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
`ifdef CMD_SCHED_ABORT_EN
    logic        ABORT;
`endif
    logic        REQ_COMM, IMP, BLANK, NCO_LOAD, CHIRP_EN, BUSY, ERR_LATE;
    logic [47:0] NCO_FREQ, NCO_STEP;
    logic [31:0] NCO_RATE;
    logic [15:0] IMP_CNT;

    cmd_exec_sched dut (
        .CLK          (CLK),
        .rst          (rst),
        .TIME         (TIME),
        .DATA_WR      (DATA_WR),
        .FREQ         (FREQ),
        .FREQ_STEP    (FREQ_STEP),
        .FREQ_RATE    (FREQ_RATE),
        .TIME_START   (TIME_START),
        .N_impulse    (N_impulse),
        .TYPE_impulse (TYPE_impulse),
        .Interval_Ti  (Interval_Ti),
        .Interval_Tp  (Interval_Tp),
        .Tblank1      (Tblank1),
        .Tblank2      (Tblank2),
`ifdef CMD_SCHED_ABORT_EN
        .ABORT        (ABORT),
`endif
        .REQ_COMM     (REQ_COMM),
        .IMP          (IMP),
        .BLANK        (BLANK),
        .NCO_LOAD     (NCO_LOAD),
        .NCO_FREQ     (NCO_FREQ),
        .NCO_STEP     (NCO_STEP),
        .NCO_RATE     (NCO_RATE),
        .CHIRP_EN     (CHIRP_EN),
        .BUSY         (BUSY),
        .IMP_CNT      (IMP_CNT),
        .ERR_LATE     (ERR_LATE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (!rst) TIME <= TIME + 64'd1;

    typedef struct {
        logic [63:0] t;
        logic [63:0] v;
    } ev_t;

    ev_t imp_q[$], blank_q[$], load_q[$], req_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic expect_train(input logic [63:0] ts, input int n,
                                input logic [1:0] typ,
                                input logic [47:0] freq,
                                input logic [47:0] step,
                                input int ti, input int tp,
                                input int tb1, input int tb2);
        int tpe, bl, ien;
        logic [47:0] f;
        logic [63:0] b;
        tpe = (tp == 0) ? tb1 + ti + tb2 : tp;
        bl  = (tb1 + ti + tb2 < tpe) ? tb1 + ti + tb2 : tpe;
        ien = (tb1 + ti < tpe) ? tb1 + ti : tpe;
        f   = freq;
        if (bl == tpe && n > 0) blank_q.push_back('{ts, 64'(n * tpe)});
        for (int k = 0; k < n; k++) begin
            b = ts + 64'(k * tpe);
            if (bl != tpe && bl > 0) blank_q.push_back('{b, 64'(bl)});
            if (ien > tb1) imp_q.push_back('{b + 64'(tb1), 64'(ien - tb1)});
            load_q.push_back('{b + 64'((tb1 == 0) ? 0 : tb1 - 1), {16'd0, f}});
            if (typ == 2'd2) f = f + step;
        end
    endtask

    task automatic wait_t(input logic [63:0] t);
        @(negedge CLK);
        while (TIME < t) @(negedge CLK);
    endtask

    task automatic send_cmd(input logic [63:0] ts, input logic [15:0] n,
                            input logic [1:0] typ, input logic [47:0] f,
                            input logic [47:0] st, input logic [31:0] rate,
                            input logic [31:0] ti, input logic [31:0] tp,
                            input logic [31:0] tb1, input logic [31:0] tb2);
        TIME_START = ts;  N_impulse = n;   TYPE_impulse = typ;
        FREQ = f;  FREQ_STEP = st;  FREQ_RATE = rate;
        Interval_Ti = ti;  Interval_Tp = tp;
        Tblank1 = tb1;  Tblank2 = tb2;
        DATA_WR = 1'b1;
        @(negedge CLK);
        DATA_WR = 1'b0;
    endtask

    logic        imp_p = 1'b0, blank_p = 1'b0, req_p = 1'b0;
    logic [63:0] imp_st, blank_st, req_st;
    ev_t         e;

    always @(negedge CLK) if (!rst) begin
        if (IMP && !imp_p) imp_st = TIME;
        if (!IMP && imp_p) begin
            check("imp_expected", 64'(imp_q.size() != 0), 64'd1);
            if (imp_q.size() != 0) begin
                e = imp_q.pop_front();
                check("imp_start", imp_st, e.t);
                check("imp_len", TIME - imp_st, e.v);
            end
        end
        imp_p = IMP;

        if (BLANK && !blank_p) blank_st = TIME;
        if (!BLANK && blank_p) begin
            check("blank_expected", 64'(blank_q.size() != 0), 64'd1);
            if (blank_q.size() != 0) begin
                e = blank_q.pop_front();
                check("blank_start", blank_st, e.t);
                check("blank_len", TIME - blank_st, e.v);
            end
        end
        blank_p = BLANK;

        if (REQ_COMM && !req_p) req_st = TIME;
        if (!REQ_COMM && req_p) begin
            check("req_expected", 64'(req_q.size() != 0), 64'd1);
            if (req_q.size() != 0) begin
                e = req_q.pop_front();
                check("req_start", req_st, e.t);
                check("req_len", TIME - req_st, e.v);
            end
        end
        req_p = REQ_COMM;

        if (NCO_LOAD) begin
            check("load_expected", 64'(load_q.size() != 0), 64'd1);
            if (load_q.size() != 0) begin
                e = load_q.pop_front();
                check("load_time", TIME, e.t);
                check("load_freq", {16'd0, NCO_FREQ}, e.v);
            end
        end
    end

    initial begin
        rst = 1'b1;  TIME = '0;  DATA_WR = 1'b0;
        FREQ = '0;  FREQ_STEP = '0;  FREQ_RATE = '0;  TIME_START = '0;
        N_impulse = '0;  TYPE_impulse = '0;
        Interval_Ti = '0;  Interval_Tp = '0;  Tblank1 = '0;  Tblank2 = '0;
`ifdef CMD_SCHED_ABORT_EN
        ABORT = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        check("rst_req", 64'(REQ_COMM), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_gates", 64'({IMP, BLANK, NCO_LOAD}), 64'd0);
        check("rst_err", 64'(ERR_LATE), 64'd0);
        check("rst_cnt", 64'(IMP_CNT), 64'd0);
        req_q.push_back('{64'd1, 64'd4});
        rst = 1'b0;

        // fixed train
        wait_t(64'd10);
        expect_train(64'd100, 3, 2'd0, 48'd555, 48'd0, 5, 20, 2, 3);
        req_q.push_back('{64'd161, 64'd4});
        send_cmd(64'd100, 16'd3, 2'd0, 48'd555, 48'd0, 32'd0,
                 32'd5, 32'd20, 32'd2, 32'd3);
        wait_t(64'd125);
        check("busy_mid", 64'(BUSY), 64'd1);
        check("cnt_mid", 64'(IMP_CNT), 64'd1);
        wait_t(64'd170);
        check("cnt_done", 64'(IMP_CNT), 64'd3);
        check("busy_done", 64'(BUSY), 64'd0);

        // hop
        wait_t(64'd200);
        expect_train(64'd250, 3, 2'd2, 48'd1000, 48'd10, 4, 10, 0, 2);
        req_q.push_back('{64'd281, 64'd4});
        send_cmd(64'd250, 16'd3, 2'd2, 48'd1000, 48'd10, 32'd0,
                 32'd4, 32'd10, 32'd0, 32'd2);

        // hop with 48-bit wrap
        wait_t(64'd300);
        expect_train(64'd350, 2, 2'd2, 48'hFFFF_FFFF_FFFB, 48'd10,
                     2, 8, 1, 1);
        req_q.push_back('{64'd367, 64'd4});
        send_cmd(64'd350, 16'd2, 2'd2, 48'hFFFF_FFFF_FFFB, 48'd10, 32'd0,
                 32'd2, 32'd8, 32'd1, 32'd1);

        // N = 0
        wait_t(64'd400);
        req_q.push_back('{64'd403, 64'd4});
        send_cmd(64'd450, 16'd0, 2'd0, 48'd1, 48'd0, 32'd0,
                 32'd5, 32'd20, 32'd2, 32'd3);
        wait_t(64'd420);
        check("n0_err", 64'(ERR_LATE), 64'd0);

        // late
        wait_t(64'd500);
        req_q.push_back('{64'd503, 64'd4});
        send_cmd(64'd501, 16'd2, 2'd0, 48'd1, 48'd0, 32'd0,
                 32'd5, 32'd20, 32'd2, 32'd3);
        wait_t(64'd520);
        check("late_err", 64'(ERR_LATE), 64'd1);

        // pending: C overwrites B, runs straight after A
        wait_t(64'd600);
        expect_train(64'd650, 2, 2'd0, 48'd42, 48'd0, 3, 10, 1, 1);
        expect_train(64'd680, 1, 2'd1, 48'd77, 48'd3, 4, 12, 2, 2);
        req_q.push_back('{64'd693, 64'd4});
        send_cmd(64'd650, 16'd2, 2'd0, 48'd42, 48'd0, 32'd0,
                 32'd3, 32'd10, 32'd1, 32'd1);
        wait_t(64'd655);
        send_cmd(64'd700, 16'd1, 2'd0, 48'd99, 48'd0, 32'd0,
                 32'd3, 32'd10, 32'd1, 32'd1);
        wait_t(64'd660);
        send_cmd(64'd680, 16'd1, 2'd1, 48'd77, 48'd3, 32'd1234,
                 32'd4, 32'd12, 32'd2, 32'd2);
        wait_t(64'd685);
        check("chirp_en", 64'(CHIRP_EN), 64'd1);
        check("nco_rate", 64'(NCO_RATE), 64'd1234);
        check("nco_step", 64'(NCO_STEP), 64'd3);

        // blank window wider than the period
        wait_t(64'd800);
        expect_train(64'd850, 2, 2'd0, 48'd5, 48'd0, 15, 20, 10, 5);
        req_q.push_back('{64'd891, 64'd4});
        send_cmd(64'd850, 16'd2, 2'd0, 48'd5, 48'd0, 32'd0,
                 32'd15, 32'd20, 32'd10, 32'd5);

`ifdef CMD_SCHED_ABORT_EN
        wait_t(64'd1000);
        imp_q.push_back('{64'd1052, 64'd4});
        blank_q.push_back('{64'd1050, 64'd6});
        load_q.push_back('{64'd1051, 64'd9});
        req_q.push_back('{64'd1057, 64'd4});
        send_cmd(64'd1050, 16'd3, 2'd0, 48'd9, 48'd0, 32'd0,
                 32'd10, 32'd20, 32'd2, 32'd2);
        wait_t(64'd1010);
        send_cmd(64'd1200, 16'd1, 2'd0, 48'd8, 48'd0, 32'd0,
                 32'd3, 32'd10, 32'd1, 32'd1);
        wait_t(64'd1055);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_imp", 64'(IMP), 64'd0);
        wait_t(64'd1300);
`else
        wait_t(64'd950);
`endif

        check("imp_left", 64'(imp_q.size()), 64'd0);
        check("blank_left", 64'(blank_q.size()), 64'd0);
        check("load_left", 64'(load_q.size()), 64'd0);
        check("req_left", 64'(req_q.size()), 64'd0);
        check("end_gates", 64'({IMP, BLANK, REQ_COMM}), 64'd0);
        check("end_busy", 64'(BUSY), 64'd0);
        check("end_err", 64'(ERR_LATE), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_exec_sched.md
Name: cmd_exec_sched

Overview:
- Executes one synthesiser command at a time from the command-memory writer (DATA_WR plus the command field bus).
- Waits until system TIME reaches TIME_START, then sequences N impulses: pulse gate, blanking gate and per-impulse NCO load.
- Pulses REQ_COMM back to the writer when the train ends or the command is dropped, so the writer supplies the next-earliest command.
- Sits between the command-memory writer and the NCO/impulse former; runs at 48 MHz, and TIME advances by 1 per CLK.

Parameters:
- REQ_LEN, 4, number of cycles REQ_COMM is held high (at least 3, to satisfy the writer's edge detector).
- ARM_MARGIN, 2, minimum cycles between command latch and TIME_START; tighter commands are dropped as late.

Ports:
- CLK  in  1  system clock, 48 MHz
- rst  in  1  asynchronous, active-high reset
- TIME  in  64  system time, +1 per CLK
- DATA_WR  in  1  command strobe; fields are valid while it is high
- FREQ, FREQ_STEP  in  48 each  start frequency word; step word
- FREQ_RATE  in  32  chirp rate
- TIME_START  in  64  absolute start time
- N_impulse  in  16  impulse count
- TYPE_impulse  in  2  0 = fixed, 1 = chirp, 2 = hop, 3 = reserved (treated as 0)
- Interval_Ti, Interval_Tp, Tblank1, Tblank2  in  32 each  pulse width, period, pre-blank, post-blank (cycles)
- REQ_COMM  out  1  next-command request
- IMP  out  1  pulse gate
- BLANK  out  1  receiver blanking gate
- NCO_LOAD  out  1  one-cycle strobe; NCO_FREQ/NCO_STEP/NCO_RATE are valid with it
- NCO_FREQ, NCO_STEP  out  48 each
- NCO_RATE  out  32
- CHIRP_EN  out  1  high when TYPE = 1
- BUSY  out  1  high in any state other than IDLE
- IMP_CNT  out  16  impulses completed in the current train
- ERR_LATE  out  1  sticky; cleared only by reset

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; pending slot empty.
- REQ_COMM after reset: asserted once, REQ_LEN cycles starting on the first cycle after rst deasserts.
- Command capture: on a DATA_WR rising edge all fields are latched in one cycle. If idle, the command goes to the active register; if BUSY, it goes to a single pending slot, and a newer command overwrites an occupied slot.
- IDLE -> ARM when the active register is loaded (from DATA_WR, or from pending at the end of the previous train).
- ARM (1 cycle):
  - N_impulse == 0 -> DONE, no error.
  - TIME + ARM_MARGIN >= TIME_START -> set ERR_LATE, go to DONE.
  - Otherwise -> WAIT_START.
  - Tp == 0 is treated as Tp = Tblank1 + Ti + Tblank2.
- WAIT_START: compare TIME == TIME_START - 1, so the first period begins exactly when TIME == TIME_START. A TIME jump past TIME_START (TIME > TIME_START) sets ERR_LATE and goes to DONE.
- PERIOD (one offset counter 0..Tp-1 per impulse):
  - BLANK = 1 for offsets [0, Tblank1 + Ti + Tblank2), clipped at Tp.
  - IMP = 1 for offsets [Tblank1, Tblank1 + Ti), clipped at Tp.
  - NCO_LOAD pulses at offset Tblank1 - 1, or at offset 0 when Tblank1 == 0 (coincident with IMP rise in that case).
  - NCO_FREQ = FREQ + k*FREQ_STEP mod 2^48 for TYPE 2 (k = impulse index); FREQ otherwise.
  - NCO_STEP = FREQ_STEP and NCO_RATE = FREQ_RATE, presented with every load.
  - At offset Tp-1: IMP_CNT increments; the train ends when IMP_CNT reaches N_impulse, otherwise the next period starts with no gap.
- DONE (1 cycle):
  - Pending occupied -> move it to active, go to ARM, REQ_COMM not asserted.
  - Pending empty -> assert REQ_COMM for REQ_LEN cycles, go to IDLE.
- A DATA_WR arriving during REQ_COMM is accepted normally; REQ_COMM still completes its full length.
- Arithmetic: the offset counter is 33-bit to avoid overflow of Tblank1 + Ti + Tblank2; TIME compares are unsigned 64-bit.

Optional Feature:
- Macro: CMD_SCHED_ABORT_EN.
- When defined: adds input ABORT (1 bit). ABORT high in any BUSY state, on the next cycle:
  - forces IMP, BLANK and NCO_LOAD to 0;
  - clears the pending slot;
  - goes to DONE, which therefore issues REQ_COMM.
- When undefined: no port is added and trains always run to completion.

Decomposition:
- Package cmd_sched_pkg:
  - state enum {IDLE, ARM, WAIT_START, PERIOD, DONE};
  - TYPE_impulse codes;
  - packed cmd_t struct, 338 bits, field order TIME_START, FREQ, FREQ_STEP, FREQ_RATE, N, TYPE, Ti, Tp, Tb1, Tb2.
- Sub-module imp_timer: the offset counter plus IMP/BLANK/NCO_LOAD window decode. Inputs Tp, Ti, Tb1, Tb2, start; outputs gates and period_end.

Test Plan:
- Fixed train: rst released at TIME = 0, REQ_COMM high for cycles 1-4. DATA_WR {TIME_START = 100, N = 3, Ti = 5, Tp = 20, Tb1 = 2, Tb2 = 3, TYPE = 0} -> IMP high TIME 102-106, 122-126, 142-146; BLANK high 100-109, 120-129, 140-149; REQ_COMM high 4 cycles starting 2 cycles after TIME 159 (DONE at 160).
- Hop: TYPE = 2, FREQ = 1000, FREQ_STEP = 10, N = 3 -> NCO_FREQ at the three loads = 1000, 1010, 1020. Wrap case FREQ = 2^48 - 5, FREQ_STEP = 10 -> second load value 5.
- Late: TIME = 500, DATA_WR with TIME_START = 501 -> ERR_LATE = 1, no IMP, REQ_COMM pulse.
- Pending: second DATA_WR during the first train -> it runs straight after the first with no REQ_COMM between them. A third DATA_WR before the first train ends replaces the second.
- Boundaries: N = 0 -> REQ_COMM only, ERR_LATE stays 0. Tb1 + Ti + Tb2 = 30 with Tp = 20 -> BLANK continuously high, IMP clipped to offsets [Tb1, 20).
- CMD_SCHED_ABORT_EN: ABORT mid-pulse -> IMP = 0 on the next cycle, REQ_COMM follows, pending cleared.
